// File: rtl/hazard3_sync_1bit.sv
// rtl/hazard3_sync_1bit.sv - multi-flop synchroniser for a single asynchronous bit
module hazard3_sync_1bit #(
    parameter int N_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i,
    output logic o
);

    // First stage may go metastable; later stages give it a full cycle each to settle.
    logic [N_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the chain, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N_STAGES-2:0], i};
        end
    end

    assign o = sync_q[N_STAGES-1];

endmodule

// File: rtl/hazard3_cdc_handshake_tx.sv
// rtl/hazard3_cdc_handshake_tx.sv - launching end of a two-phase req/ack clock crossing
module hazard3_cdc_handshake_tx #(
    parameter int W_DATA = 32,
    parameter int N_SYNC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [W_DATA-1:0] src_data,
    output logic              cdc_req,
    output logic [W_DATA-1:0] cdc_data,
    input  logic              cdc_ack,
    output logic              busy
);

    logic req_q;
    logic [W_DATA-1:0] data_q;
    logic ack_sync;
    logic idle;
    logic accept;

    // Bring the far-domain acknowledge toggle into the local clock domain.
    hazard3_sync_1bit #(
        .N_STAGES (N_SYNC)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (cdc_ack),
        .o     (ack_sync)
    );

    // Idle when the last request toggle has been answered. Both operands are flops,
    // so src_ready has no combinational path from any input.
    assign idle   = (req_q == ack_sync);
    assign accept = src_valid && idle;

    // Request toggle: one edge per accepted word, driven straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
        end else if (accept) begin
            req_q <= ~req_q;
        end
    end

    // Held word: written only on accept, so it is quasi-static while the far end
    // is synchronising the request and sampling the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (accept) begin
            data_q <= src_data;
        end
    end

    assign src_ready = idle;
    assign busy      = ~idle;
    assign cdc_req   = req_q;
    assign cdc_data  = data_q;

endmodule

// File: tb/tb_hazard3_cdc_handshake_tx.sv
// tb/tb_hazard3_cdc_handshake_tx.sv - directed self-checking bench for hazard3_cdc_handshake_tx
module tb_hazard3_cdc_handshake_tx;

    logic        clk = 1'b0;
    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;

    logic        src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic        src_ready;
    logic        cdc_req;
    logic [31:0] cdc_data;
    logic        cdc_ack;
    logic        busy;
    logic        ack_drv = 1'b0;

    logic        p_valid = 1'b0;
    logic [7:0]  p_data = '0;
    logic        p_ready;
    logic        p_req;
    logic [7:0]  p_cdc_data;
    logic        p_ack = 1'b0;
    logic        p_busy;

    logic        far_en = 1'b0;
    logic        f_s1 = 1'b0;
    logic        f_s2 = 1'b0;
    logic        f_ack = 1'b0;
    logic [31:0] rx_data [0:31];
    int          rx_cnt = 0;

    logic        cnt_en = 1'b0;
    logic        req_prev = 1'b0;
    int          tog_cnt = 0;

    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always #7 fclk = ~fclk;

    assign cdc_ack = far_en ? f_ack : ack_drv;

    hazard3_cdc_handshake_tx #(
        .W_DATA (32),
        .N_SYNC (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .cdc_req   (cdc_req),
        .cdc_data  (cdc_data),
        .cdc_ack   (cdc_ack),
        .busy      (busy)
    );

    hazard3_cdc_handshake_tx #(
        .W_DATA (8),
        .N_SYNC (3)
    ) dut_p (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (p_valid),
        .src_ready (p_ready),
        .src_data  (p_data),
        .cdc_req   (p_req),
        .cdc_data  (p_cdc_data),
        .cdc_ack   (p_ack),
        .busy      (p_busy)
    );

    // Behavioural far end: 2FF request sync on its own clock, capture, immediate ack.
    always @(posedge fclk) begin
        if (!far_en) begin
            f_s1  <= cdc_req;
            f_s2  <= cdc_req;
            f_ack <= ack_drv;
        end else begin
            f_s1 <= cdc_req;
            f_s2 <= f_s1;
            if (f_s2 != f_ack) begin
                if (rx_cnt < 32) rx_data[rx_cnt] <= cdc_data;
                rx_cnt <= rx_cnt + 1;
                f_ack  <= f_s2;
            end
        end
    end

    // Count request toggles while the stream phase is active.
    always @(negedge clk) begin
        if (cnt_en && (cdc_req != req_prev)) tog_cnt++;
        req_prev = cdc_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int wait_cyc;

        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            src_valid = 1'($urandom);
            src_data  = $urandom;
            p_valid   = 1'($urandom);
            p_data    = 8'($urandom);
            check("reset_req", {31'd0, cdc_req}, 32'd0);
            check("reset_data", cdc_data, 32'd0);
            check("reset_ready", {31'd0, src_ready}, 32'd1);
            check("reset_busy", {31'd0, busy}, 32'd0);
        end
        src_valid = 1'b0;
        p_valid   = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {31'd0, src_ready}, 32'd1);

        // 2 + 3: single transfer, ack toggled after edge 5, hold while busy
        src_valid = 1'b1;
        src_data  = 32'hDEADBEEF;
        @(posedge clk);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            check("single_ready_low", {31'd0, src_ready}, 32'd0);
            if (j == 0) begin
                check("single_req", {31'd0, cdc_req}, 32'd1);
                check("single_data", cdc_data, 32'hDEADBEEF);
                src_valid = 1'b0;
            end
            if (j == 1) begin
                src_valid = 1'b1;
                src_data  = 32'h12345678;
            end
            if (j >= 3) begin
                check("hold_data", cdc_data, 32'hDEADBEEF);
                check("hold_req", {31'd0, cdc_req}, 32'd1);
            end
            if (j == 5) begin
                check("ack_only_when_busy", {31'd0, busy}, 32'd1);
                ack_drv = ~ack_drv;
            end
            @(posedge clk);
        end
        @(negedge clk);
        src_valid = 1'b0;
        check("single_ready_back", {31'd0, src_ready}, 32'd1);
        check("single_busy_clear", {31'd0, busy}, 32'd0);
        check("single_data_kept", cdc_data, 32'hDEADBEEF);

        // 4: stream of 16 words through the behavioural far end
        far_en = 1'b1;
        repeat (3) @(negedge clk);
        cnt_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            src_valid = 1'b1;
            src_data  = i;
            wait_cyc  = 0;
            while (!src_ready && wait_cyc < 100) begin
                @(negedge clk);
                wait_cyc++;
            end
            if (wait_cyc >= 100) check("stream_ready_timeout", {31'd0, src_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            src_valid = 1'b0;
        end
        wait_cyc = 0;
        while ((rx_cnt < 16 || !src_ready) && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        repeat (4) @(negedge clk);
        cnt_en = 1'b0;
        check("stream_rx_count", rx_cnt, 32'd16);
        check("stream_toggles", tog_cnt, 32'd16);
        for (int i = 0; i < 16; i++) check("stream_word", rx_data[i], i);
        ack_drv = f_ack;
        @(negedge clk);
        far_en = 1'b0;

        // 5: reset mid-transfer
        rst_n   = 1'b0;
        ack_drv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        src_valid = 1'b1;
        src_data  = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        src_valid = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_req", {31'd0, cdc_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_reset_req", {31'd0, cdc_req}, 32'd0);
        check("mid_reset_ready", {31'd0, src_ready}, 32'd1);
        check("mid_reset_data", cdc_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        src_valid = 1'b1;
        src_data  = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        src_valid = 1'b0;
        check("after_reset_req", {31'd0, cdc_req}, 32'd1);
        check("after_reset_data", cdc_data, 32'hA5A5A5A5);
        check("after_reset_busy", {31'd0, busy}, 32'd1);
        ack_drv = ~ack_drv;
        wait_cyc = 0;
        while (!src_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("after_reset_done", {31'd0, src_ready}, 32'd1);
        check("after_reset_wait", wait_cyc, 32'd2);
        check("after_reset_held", cdc_data, 32'hA5A5A5A5);

        // 6: N_SYNC=3, W_DATA=8 instance
        @(negedge clk);
        check("p_idle", {31'd0, p_ready}, 32'd1);
        p_valid = 1'b1;
        p_data  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        p_valid = 1'b0;
        check("p_req", {31'd0, p_req}, 32'd1);
        check("p_data", {24'd0, p_cdc_data}, 32'h5A);
        @(posedge clk);
        @(negedge clk);
        check("p_busy_before_ack", {31'd0, p_busy}, 32'd1);
        p_ack = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            check("p_ready_edge", {31'd0, p_ready}, (j == 3) ? 32'd1 : 32'd0);
            check("p_data_stable", {24'd0, p_cdc_data}, 32'h5A);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
